// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared helpers for clock-domain-crossing pointer logic.
//   CDC_MIN_STAGES : smallest legal synchroniser depth
//   CDC_MAX_W      : widest pointer the helper functions handle
//   gray2bin()     : Gray -> binary (prefix XOR from the MSB)
//   popcount()     : number of set bits
// Both functions work on zero-extended CDC_MAX_W-bit values, so a caller with
// a narrower pointer widens it on the way in and truncates the result; zero
// upper bits leave the lower bits of the conversion unchanged.
// -----------------------------------------------------------------------------
package cdc_pkg;

  localparam int CDC_MIN_STAGES = 2;
  localparam int CDC_MAX_W      = 32;

  function automatic logic [CDC_MAX_W-1:0] gray2bin(input logic [CDC_MAX_W-1:0] g);
    logic [CDC_MAX_W-1:0] b;
    b[CDC_MAX_W-1] = g[CDC_MAX_W-1];
    for (int i = CDC_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [CDC_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < CDC_MAX_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cdc_ptr_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Generic WIDTH x STAGES flop chain for bringing a signal into clk's domain.
// Nothing sits between stages so each flop has a full period to resolve
// metastability. Also usable for single-bit control synchronisers.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears every stage
//   d_i  : asynchronous input
//   q_o  : last stage output
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q[0] <= '0;
    end else begin
      stage_q[0] <= d_i;
    end
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q[gi] <= '0;
      end else begin
        stage_q[gi] <= stage_q[gi-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/cdc_ptr_sync.sv
// -----------------------------------------------------------------------------
// cdc_ptr_sync
// Destination-side synchroniser for a Gray-coded async-FIFO pointer, with
// registered binary conversion, advance pulse, step size and Gray checking.
//   clk       : destination clock
//   rst       : asynchronous active-high reset
//   in_gray   : Gray pointer from the source domain (asynchronous)
//   clr_err   : synchronous clear of gray_err / err_cnt
//   sync_gray : synchronised Gray pointer (STAGES edges of latency)
//   sync_bin  : binary of sync_gray, one edge later
//   changed   : one-cycle pulse per observed pointer change
//   delta     : binary step of the last change, mod 2^WIDTH (held otherwise)
//   gray_err  : sticky flag, an observed change flipped two or more bits
//   err_cnt   : saturating count of such changes
// -----------------------------------------------------------------------------
module cdc_ptr_sync
  import cdc_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int STAGES    = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_gray,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     sync_gray,
  output logic [WIDTH-1:0]     sync_bin,
  output logic                 changed,
  output logic [WIDTH-1:0]     delta,
  output logic                 gray_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (STAGES < CDC_MIN_STAGES) begin : g_bad_stages
    $error("cdc_ptr_sync: STAGES must be at least %0d", CDC_MIN_STAGES);
  end
  if (WIDTH < 2 || WIDTH > CDC_MAX_W) begin : g_bad_width
    $error("cdc_ptr_sync: WIDTH must be in 2..%0d", CDC_MAX_W);
  end

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0]     sync_gray_w;
  logic [WIDTH-1:0]     prev_gray_q;
  logic [WIDTH-1:0]     sync_bin_q, sync_bin_d;
  logic                 changed_q, changed_d;
  logic [WIDTH-1:0]     delta_q, delta_d;
  logic                 gray_err_q, gray_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]     prev_bin;
  logic [WIDTH-1:0]     xd;
  logic                 violation;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_chain (
    .clk (clk),
    .rst (rst),
    .d_i (in_gray),
    .q_o (sync_gray_w)
  );

  // Widen into the package helpers, truncate straight back to WIDTH.
  assign prev_bin  = WIDTH'(gray2bin(CDC_MAX_W'(prev_gray_q)));
  assign xd        = sync_gray_w ^ prev_gray_q;
  assign violation = popcount(CDC_MAX_W'(xd)) >= 2;

  always_comb begin
    sync_bin_d = WIDTH'(gray2bin(CDC_MAX_W'(sync_gray_w)));
    changed_d  = (xd != '0);
    delta_d    = delta_q;
    gray_err_d = gray_err_q;
    err_cnt_d  = err_cnt_q;
    if (xd != '0) begin
      delta_d = sync_bin_d - prev_bin;
    end
    // A violation outranks a same-cycle clear: the clear empties the count,
    // then the new violation is the first one counted.
    if (violation) begin
      gray_err_d = 1'b1;
      if (clr_err) begin
        err_cnt_d = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end else if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (clr_err) begin
      gray_err_d = 1'b0;
      err_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gray_q <= '0;
      sync_bin_q  <= '0;
      changed_q   <= 1'b0;
      delta_q     <= '0;
      gray_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      prev_gray_q <= sync_gray_w;
      sync_bin_q  <= sync_bin_d;
      changed_q   <= changed_d;
      delta_q     <= delta_d;
      gray_err_q  <= gray_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign sync_gray = sync_gray_w;
  assign sync_bin  = sync_bin_q;
  assign changed   = changed_q;
  assign delta     = delta_q;
  assign gray_err  = gray_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cdc_ptr_sync.sv
module tb_cdc_ptr_sync;

  typedef struct {
    logic [4:0] bin;
    logic [4:0] dlt;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] in_gray = 5'b11111;
  logic       clr_err = 1'b0;
  logic [4:0] sync_gray, sync_bin, delta;
  logic       changed, gray_err;
  logic [7:0] err_cnt;

  logic       rst3 = 1'b1;
  logic [4:0] in3 = 5'b11111;
  logic       clr3 = 1'b0;
  logic [4:0] sync_gray3, sync_bin3, delta3;
  logic       changed3, gray_err3;
  logic [7:0] err_cnt3;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cdc_ptr_sync #(.WIDTH(5), .STAGES(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_gray(in_gray), .clr_err(clr_err),
    .sync_gray(sync_gray), .sync_bin(sync_bin), .changed(changed),
    .delta(delta), .gray_err(gray_err), .err_cnt(err_cnt)
  );

  cdc_ptr_sync #(.WIDTH(5), .STAGES(3), .ERR_CNT_W(8)) dut3 (
    .clk(clk), .rst(rst3), .in_gray(in3), .clr_err(clr3),
    .sync_gray(sync_gray3), .sync_bin(sync_bin3), .changed(changed3),
    .delta(delta3), .gray_err(gray_err3), .err_cnt(err_cnt3)
  );

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int bin, input int dlt, input logic err, input int cnt);
    exp_t e;
    e.bin = 5'(bin);
    e.dlt = 5'(dlt);
    e.err = err;
    e.cnt = 8'(cnt);
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the changed pulse, then pop and compare the scoreboard.
  task automatic wait_change(input string tag);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (changed !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    check({tag, " changed"}, changed, 1);
    check({tag, " queued"}, exp_q.size() > 0, 1);
    if (changed === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " sync_bin"}, sync_bin, e.bin);
      check({tag, " delta"}, delta, e.dlt);
      check({tag, " gray_err"}, gray_err, e.err);
      check({tag, " err_cnt"}, err_cnt, e.cnt);
      $display("txn %s: bin=%0d delta=%0d err=%0b cnt=%0d", tag, sync_bin, delta, gray_err, err_cnt);
    end
    step();
    check({tag, " pulse_end"}, changed, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. reset with all-ones input
    repeat (3) step();
    check("rst sync_gray", sync_gray, 0);
    check("rst sync_bin", sync_bin, 0);
    check("rst changed", changed, 0);
    check("rst delta", delta, 0);
    check("rst gray_err", gray_err, 0);
    check("rst err_cnt", err_cnt, 0);
    in_gray = 5'd0;
    in3     = 5'd0;
    rst     = 1'b0;
    rst3    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst changed", changed, 0);
    end
    $display("txn reset: outputs zero, no change pulse");

    // 2. exact latency of a single step 0 -> 1
    in_gray = 5'b00001;
    push(1, 1, 0, 0);
    step();
    check("lat e sync_gray", sync_gray, 0);
    step();
    check("lat e+1 sync_gray", sync_gray, 1);
    check("lat e+1 changed", changed, 0);
    step();
    check("lat e+2 changed", changed, 1);
    wait_change("lat");

    // 3. Gray count 2..31 and wrap to 0, each held 4 clocks
    for (int v = 2; v <= 32; v++) begin
      in_gray = to_gray(v % 32);
      push(v % 32, 1, 0, 0);
      wait_change($sformatf("count%0d", v % 32));
    end

    // 4. single steps 1,2,3 then jump 3 -> 6, then single step 6 -> 7
    for (int v = 1; v <= 3; v++) begin
      in_gray = to_gray(v);
      push(v, 1, 0, 0);
      wait_change($sformatf("walk%0d", v));
    end
    in_gray = to_gray(6);
    push(6, 3, 1, 1);
    wait_change("jump3to6");
    in_gray = to_gray(7);
    push(7, 1, 1, 1);
    wait_change("step6to7");

    // 5a. clr_err in the same cycle as a new violation (7 -> 12)
    in_gray = to_gray(12);
    push(12, 5, 1, 1);
    step();
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    wait_change("clr_with_viol");

    // 5b. clr_err alone
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr gray_err", gray_err, 0);
    check("clr err_cnt", err_cnt, 0);
    check("clr sync_bin", sync_bin, 12);
    $display("txn clr_err: err=%0b cnt=%0d", gray_err, err_cnt);

    // 5c. 300 back-to-back two-bit flips saturate the counter
    for (int i = 0; i < 300; i++) begin
      in_gray = (i % 2 == 1) ? 5'b01010 : 5'b00000;
      step();
    end
    repeat (4) step();
    check("sat err_cnt", err_cnt, 255);
    check("sat gray_err", gray_err, 1);
    check("sat sync_bin", sync_bin, 12);
    check("sat delta", delta, 12);
    $display("txn saturate: cnt=%0d", err_cnt);

    // 6. STAGES=3 latency, then async reset with a value in flight
    in3 = 5'b00001;
    step();
    check("s3 e sync_gray", sync_gray3, 0);
    step();
    check("s3 e+1 sync_gray", sync_gray3, 0);
    step();
    check("s3 e+2 sync_gray", sync_gray3, 1);
    check("s3 e+2 sync_bin", sync_bin3, 0);
    check("s3 e+2 changed", changed3, 0);
    step();
    check("s3 e+3 sync_bin", sync_bin3, 1);
    check("s3 e+3 changed", changed3, 1);
    check("s3 e+3 delta", delta3, 1);
    $display("txn s3_latency: bin=%0d delta=%0d", sync_bin3, delta3);
    in3 = to_gray(2);
    step();
    #2;
    rst3 = 1'b1;
    #1;
    check("s3 arst sync_gray", sync_gray3, 0);
    check("s3 arst sync_bin", sync_bin3, 0);
    check("s3 arst delta", delta3, 0);
    check("s3 arst changed", changed3, 0);
    in3 = 5'd0;
    step();
    step();
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("s3 flight sync_gray", sync_gray3, 0);
      check("s3 flight changed", changed3, 0);
    end
    $display("txn s3_reset: in-flight value discarded");

    check("scoreboard empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
